serial_subtractor: RTL

//   Bit-serial N-bit subtractor: computes diff = a - b - borrow_in one bit per clock, LSB first.

---
 rtl/arith_pkg.sv | 16 +
 rtl/full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//   Shared definitions for the bit-serial arithmetic datapaths (serial adder
//   and serial subtractor).
//   Contents:
//     state_t  - control FSM encoding: ST_IDLE=0, ST_SHIFT=1, ST_DONE=2
// ---------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational full subtractor: {borrow_out, diff} = a - b - borrow_in.
//   Ports:
//     diff        out  difference bit
//     borrow_out  out  borrow generated by this bit position
//     a           in   minuend bit
//     b           in   subtrahend bit
//     borrow_in   in   borrow from the previous (less significant) bit
// ---------------------------------------------------------------------------
module full_subtractor (
    output logic diff,
    output logic borrow_out,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    assign diff       = a ^ b ^ borrow_in;
    // Borrow when b exceeds a outright, or when a == b and a borrow is pending.
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, one bit per
//   clock, LSB first, through a single full_subtractor cell and a borrow flop.
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   synchronous active-high reset (priority over start)
//     start       in   request; a/b/borrow_in sampled on the accepting edge
//     a, b        in   minuend / subtrahend (WIDTH bits)
//     borrow_in   in   initial borrow
//     busy        out  high while in SHIFT
//     done        out  one-cycle pulse, diff/borrow_out valid
//     diff        out  result, held until the next completed operation
//     borrow_out  out  final borrow, held like diff
//
//   Handshake: start is accepted only in IDLE or DONE (back-to-back). Once
//   accepted, the operation runs for WIDTH SHIFT cycles, then DONE asserts
//   done for exactly one cycle. start while busy is ignored, nothing is queued.
//   The FSM state is held in state_q for observation.
// ---------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // One extra bit keeps the counter well formed for WIDTH=1.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               br_q, br_d;
    logic               bo_q, bo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               d_bit;
    logic               bo_bit;
    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   res_shift;

    full_subtractor u_fs (
        .diff       (d_bit),
        .borrow_out (bo_bit),
        .a          (a_sr_q[0]),
        .b          (b_sr_q[0]),
        .borrow_in  (br_q)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // New result bit enters from the MSB so that after WIDTH shifts the
    // first (LSB) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = d_bit;
        end else begin : g_res_wn
            assign res_shift = {d_bit, res_q[WIDTH-1:1]};
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values. The outputs are captured on the final SHIFT
    // edge, so they are valid in the DONE cycle and never partially updated.
    always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        res_d  = res_q;
        diff_d = diff_q;
        br_d   = br_q;
        bo_d   = bo_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_sr_d = a;
            b_sr_d = b;
            br_d   = borrow_in;
            res_d  = '0;
            cnt_d  = '0;
        end else if (state_q == ST_SHIFT) begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            br_d   = bo_bit;
            res_d  = res_shift;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_bit) begin
                diff_d = res_shift;
                bo_d   = bo_bit;
            end
        end
    end

    // Outputs decoded from state.
    always_comb begin
        busy       = (state_q == ST_SHIFT);
        done       = (state_q == ST_DONE);
        diff       = diff_q;
        borrow_out = bo_q;
    end

endmodule
